// File: rtl/serial_rx_arbiter_if.sv
// Channel-side and ctrl-TX-side signal bundle of serial_rx_arbiter.
// slave = arbiter view, master = channel/serializer environment view.
interface serial_rx_arbiter_if #(
   parameter int unsigned D_W    = 8,
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned PRIO_W = 3
);
   logic                     enable;
   logic [NUM_CH-1:0]        chan_req;
   logic [NUM_CH*PRIO_W-1:0] chan_prio;
   logic [NUM_CH*D_W-1:0]    chan_data;
   logic [NUM_CH-1:0]        chan_grant;
   logic                     commit_read;
   logic                     ctrl_tx_ok_2_ld;
   logic                     ctrl_tx_load;
   logic [D_W-1:0]           ctrl_tx_dat;
   logic                     busy;

   modport slave (
      input  enable, chan_req, chan_prio, chan_data, ctrl_tx_ok_2_ld,
      output chan_grant, commit_read, ctrl_tx_load, ctrl_tx_dat, busy
   );

   modport master (
      output enable, chan_req, chan_prio, chan_data, ctrl_tx_ok_2_ld,
      input  chan_grant, commit_read, ctrl_tx_load, ctrl_tx_dat, busy
   );
endinterface

// File: rtl/serial_rx_arbiter.sv
// Priority/round-robin arbiter framing one pending RX byte per frame onto the ctrl TX link.
// Optional age-based starvation guard: define SERIAL_ARB_STARVATION_GUARD_EN.
module serial_rx_arbiter #(
   parameter int unsigned D_W       = 8,
   parameter int unsigned NUM_CH    = 8,
   parameter int unsigned PRIO_W    = 3,
   parameter logic [D_W-$clog2(NUM_CH)-1:0] HDR_TAG = 5'b10100,
   parameter int unsigned AGE_LIMIT = 16
) (
   input logic               clk,
   input logic               rst,
   serial_rx_arbiter_if.slave bus
);
   localparam int unsigned CH_W = $clog2(NUM_CH);
   localparam int unsigned EP_W = PRIO_W + 1;

   if (((NUM_CH & (NUM_CH - 1)) != 0) || (AGE_LIMIT == 0)) begin : g_param_chk
      $error("serial_rx_arbiter: NUM_CH must be a power of 2 and AGE_LIMIT nonzero");
   end

   typedef enum logic [2:0] {IDLE, ARB, POP, HDR, GAP, DAT} state_t;

   state_t            state;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   winner;
   logic [D_W-1:0]    data_hold;
   logic [NUM_CH-1:0] grant_q;
   logic              commit_q;
   logic              load_q;
   logic [D_W-1:0]    dat_q;
   logic              busy_q;

   logic [EP_W-1:0]   eff_prio [NUM_CH];
   logic [EP_W-1:0]   best_prio;
   logic [CH_W-1:0]   scan_idx;
   logic [CH_W-1:0]   arb_idx_c;
   logic              arb_any_c;

`ifdef SERIAL_ARB_STARVATION_GUARD_EN
   localparam int unsigned AGE_W = $clog2(AGE_LIMIT + 1);
   logic [AGE_W-1:0] age [NUM_CH];

   // Aged-out channels outrank every programmable priority
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (age[i] == AGE_W'(AGE_LIMIT))
            eff_prio[i] = {1'b1, {PRIO_W{1'b0}}};
         else
            eff_prio[i] = {1'b0, bus.chan_prio[i*PRIO_W +: PRIO_W]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) age[i] <= '0;
      end else if (state == ARB) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!bus.chan_req[i] || (arb_idx_c == CH_W'(i)))
               age[i] <= '0;
            else if (age[i] != AGE_W'(AGE_LIMIT))
               age[i] <= age[i] + AGE_W'(1);
         end
      end
   end
`else
   always_comb begin
      for (int i = 0; i < NUM_CH; i++)
         eff_prio[i] = {1'b0, bus.chan_prio[i*PRIO_W +: PRIO_W]};
   end
`endif

   // Circular scan from rr_ptr; only a strictly higher priority displaces, so ties keep RR order
   always_comb begin
      arb_any_c = 1'b0;
      arb_idx_c = rr_ptr;
      best_prio = '0;
      scan_idx  = rr_ptr;
      for (int k = 0; k < NUM_CH; k++) begin
         scan_idx = rr_ptr + CH_W'(k);
         if (bus.chan_req[scan_idx] && (!arb_any_c || (eff_prio[scan_idx] > best_prio))) begin
            arb_any_c = 1'b1;
            arb_idx_c = scan_idx;
            best_prio = eff_prio[scan_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         winner    <= '0;
         data_hold <= '0;
         grant_q   <= '0;
         commit_q  <= 1'b0;
         load_q    <= 1'b0;
         dat_q     <= '0;
         busy_q    <= 1'b0;
      end else begin
         commit_q <= 1'b0;
         load_q   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.enable && (|bus.chan_req)) begin
                  state  <= ARB;
                  busy_q <= 1'b1;
               end
            end
            ARB: begin
               if (arb_any_c) begin
                  winner    <= arb_idx_c;
                  grant_q   <= NUM_CH'(1) << arb_idx_c;
                  data_hold <= bus.chan_data[arb_idx_c*D_W +: D_W];
                  state     <= POP;
               end else begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            POP: begin
               commit_q <= 1'b1;
               state    <= HDR;
            end
            HDR: begin
               if (bus.ctrl_tx_ok_2_ld) begin
                  load_q <= 1'b1;
                  dat_q  <= {HDR_TAG, winner};
                  state  <= GAP;
               end
            end
            // Serializer needs a cycle to drop ok_2_ld after the header load
            GAP: state <= DAT;
            DAT: begin
               if (bus.ctrl_tx_ok_2_ld) begin
                  load_q  <= 1'b1;
                  dat_q   <= data_hold;
                  rr_ptr  <= winner + CH_W'(1);
                  grant_q <= '0;
                  busy_q  <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.chan_grant   = grant_q;
   assign bus.commit_read  = commit_q;
   assign bus.ctrl_tx_load = load_q;
   assign bus.ctrl_tx_dat  = dat_q;
   assign bus.busy         = busy_q;
endmodule

// File: tb/tb_serial_rx_arbiter.sv
// Scoreboard bench for serial_rx_arbiter: directed frames plus randomized batches against a winner-selection model.
`timescale 1ns/1ps
module tb_serial_rx_arbiter;
   localparam int unsigned D_W       = 8;
   localparam int unsigned NUM_CH    = 8;
   localparam int unsigned PRIO_W    = 3;
   localparam int unsigned AGE_LIMIT = 4;
   localparam logic [4:0]  HDR_TAG   = 5'b10100;

   logic clk = 1'b0;
   logic rst;
   logic bp_rand;
   logic rnd_ok;
   logic ok_force;

   always #5 clk = ~clk;

   serial_rx_arbiter_if #(.D_W(D_W), .NUM_CH(NUM_CH), .PRIO_W(PRIO_W)) bus ();

   serial_rx_arbiter #(
      .D_W(D_W), .NUM_CH(NUM_CH), .PRIO_W(PRIO_W), .HDR_TAG(HDR_TAG), .AGE_LIMIT(AGE_LIMIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   assign bus.ctrl_tx_ok_2_ld = bp_rand ? rnd_ok : ok_force;

   initial begin
      rnd_ok = 1'b1;
      forever begin
         @(posedge clk);
         #1 rnd_ok = 1'($urandom_range(0, 1));
      end
   end

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_bytes  [$];
   logic [7:0] exp_grants [$];

   // Reference model state
   int         m_rr;
   int         m_age  [NUM_CH];
   int         m_prio [NUM_CH];
   logic [7:0] m_data [NUM_CH];
   logic [7:0] m_req;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every load and every pop strobe must match the predicted stream
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (bus.ctrl_tx_load === 1'b1) begin
            if (exp_bytes.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_load: got byte %0h, expected no load (t=%0t)", bus.ctrl_tx_dat, $time);
            end else begin
               e = exp_bytes.pop_front();
               check("tx_byte", 32'(bus.ctrl_tx_dat), 32'(e));
            end
         end
         if (bus.commit_read === 1'b1) begin
            if (exp_grants.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_pop: got grant %0h, expected no pop (t=%0t)", bus.chan_grant, $time);
            end else begin
               e = exp_grants.pop_front();
               check("grant_at_pop", 32'(bus.chan_grant), 32'(e));
               check("busy_at_pop", 32'(bus.busy), 32'd1);
            end
         end
      end
   end

   function automatic int eff(input int i);
      int p;
      p = m_prio[i];
`ifdef SERIAL_ARB_STARVATION_GUARD_EN
      if (m_age[i] >= int'(AGE_LIMIT)) p = 1 << PRIO_W;
`endif
      return p;
   endfunction

   // Highest effective priority wins; among equals, the first index at/after m_rr circularly
   function automatic int pick(input logic [7:0] r);
      int top;
      int w;
      int i;
      top = -1;
      w   = -1;
      for (int c = 0; c < 8; c++)
         if (r[c] && eff(c) > top) top = eff(c);
      for (int k = 0; k < 8; k++) begin
         i = (m_rr + k) % 8;
         if (w < 0 && r[i] && eff(i) == top) w = i;
      end
      return w;
   endfunction

   task automatic predict(input int n, input bit pop);
      logic [7:0] r;
      int w;
      r = m_req;
      for (int f = 0; f < n; f++) begin
         w = pick(r);
         exp_grants.push_back(8'(1) << w);
         exp_bytes.push_back({HDR_TAG, 3'(w)});
         exp_bytes.push_back(m_data[w]);
         for (int i = 0; i < 8; i++) begin
            if (!r[i] || i == w) m_age[i] = 0;
            else if (m_age[i] < int'(AGE_LIMIT)) m_age[i]++;
         end
         m_rr = (w + 1) % 8;
         if (pop) r[w] = 1'b0;
      end
   endtask

   task automatic drive_inputs();
      bus.chan_req = m_req;
      for (int i = 0; i < 8; i++) begin
         bus.chan_prio[i*PRIO_W +: PRIO_W] = 3'(m_prio[i]);
         bus.chan_data[i*D_W +: D_W]       = m_data[i];
      end
   endtask

   task automatic model_reset();
      m_rr = 0;
      for (int i = 0; i < 8; i++) m_age[i] = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.enable = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      model_reset();
   endtask

   task automatic drained();
      @(negedge clk);
      #1;
      check("queue_drained", 32'(exp_bytes.size() + exp_grants.size()), 32'd0);
   endtask

   // Predict n frames, then run with enable held until all 2n loads appear
   task automatic run_frames(input int n, input bit pop, input bit scramble);
      int loads;
      int cyc;
      predict(n, pop);
      drive_inputs();
      bus.enable = 1'b1;
      loads = 0;
      cyc   = 0;
      while (loads < 2*n && cyc < 400*n) begin
         @(posedge clk);
         #2;
         cyc++;
         if (bus.commit_read === 1'b1) begin
            if (pop) bus.chan_req = bus.chan_req & ~bus.chan_grant;
            if (scramble) begin
               bus.chan_req  = 8'($urandom);
               bus.chan_prio = 24'($urandom);
               bus.chan_data = {$urandom, $urandom};
            end
         end
         if (bus.ctrl_tx_load === 1'b1) loads++;
      end
      bus.enable = 1'b0;
      if (loads < 2*n) begin
         n_vec++;
         n_err++;
         $display("FAIL frame_timeout: got %0d loads, expected %0d", loads, 2*n);
         exp_bytes.delete();
         exp_grants.delete();
      end
      drained();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int cyc;
      int n;
      bit pop;
      bp_rand   = 1'b0;
      ok_force  = 1'b1;
      rst       = 1'b1;
      bus.enable    = 1'b0;
      bus.chan_req  = '0;
      bus.chan_prio = '0;
      bus.chan_data = '0;
      m_req = '0;
      for (int i = 0; i < 8; i++) begin
         m_prio[i] = 0;
         m_data[i] = '0;
      end
      model_reset();

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_grant",  32'(bus.chan_grant),   32'd0);
      check("rst_commit", 32'(bus.commit_read),  32'd0);
      check("rst_load",   32'(bus.ctrl_tx_load), 32'd0);
      check("rst_dat",    32'(bus.ctrl_tx_dat),  32'd0);
      check("rst_busy",   32'(bus.busy),         32'd0);
      rst = 1'b0;

      // Single request: exact cycle timing, enable dropped right after start
      @(posedge clk);
      #2;
      m_req = 8'h04;
      m_data[2] = 8'h5A;
      predict(1, 1'b0);
      drive_inputs();
      bus.enable = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(posedge clk);
         #2;
         if (c == 1) bus.enable = 1'b0;
         check("commit_timing", 32'(bus.commit_read), (c == 3) ? 32'd1 : 32'd0);
         check("load_timing", 32'(bus.ctrl_tx_load), (c == 4 || c == 6) ? 32'd1 : 32'd0);
         check("grant_hold", 32'(bus.chan_grant), (c >= 2 && c <= 5) ? 32'h04 : 32'd0);
         check("busy_timing", 32'(bus.busy), (c >= 1 && c <= 5) ? 32'd1 : 32'd0);
      end
      drained();

      // Priority: ch6 (prio 7) before ch1 (prio 2); channels drop req once popped
      m_req = 8'h42;
      for (int i = 0; i < 8; i++) begin
         m_prio[i] = 0;
         m_data[i] = 8'($urandom);
      end
      m_prio[1] = 2;
      m_prio[6] = 7;
      run_frames(2, 1'b1, 1'b0);

      // Backpressure: 20 stalled cycles in HDR with grant stable
      m_req = 8'h10;
      m_data[4] = 8'($urandom);
      ok_force = 1'b0;
      predict(1, 1'b0);
      drive_inputs();
      bus.enable = 1'b1;
      cyc = 0;
      while (bus.commit_read !== 1'b1 && cyc < 20) begin
         @(posedge clk);
         #2;
         cyc++;
      end
      bus.enable = 1'b0;
      check("bp_pop_seen", 32'(bus.commit_read), 32'd1);
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #2;
         check("bp_no_load", 32'(bus.ctrl_tx_load), 32'd0);
         check("bp_busy",    32'(bus.busy),         32'd1);
         check("bp_grant",   32'(bus.chan_grant),   32'h10);
      end
      ok_force = 1'b1;
      @(posedge clk);
      #2;
      check("bp_hdr_load", 32'(bus.ctrl_tx_load), 32'd1);
      cyc = 0;
      do begin
         @(posedge clk);
         #2;
         cyc++;
      end while (bus.ctrl_tx_load !== 1'b1 && cyc < 20);
      check("bp_dat_load", 32'(bus.ctrl_tx_load), 32'd1);
      drained();

      // Reset in GAP: frame aborted, data byte never loaded
      m_req = 8'h20;
      m_data[5] = 8'($urandom);
      predict(1, 1'b0);
      drive_inputs();
      bus.enable = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk);
         #2;
         cyc++;
      end while (bus.ctrl_tx_load !== 1'b1 && cyc < 20);
      bus.enable = 1'b0;
      check("mid_hdr_seen", 32'(bus.ctrl_tx_load), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #2;
      exp_bytes.delete();
      exp_grants.delete();
      rst = 1'b0;
      model_reset();
      check("mid_rst_grant",  32'(bus.chan_grant),   32'd0);
      check("mid_rst_commit", 32'(bus.commit_read),  32'd0);
      check("mid_rst_load",   32'(bus.ctrl_tx_load), 32'd0);
      check("mid_rst_dat",    32'(bus.ctrl_tx_dat),  32'd0);
      check("mid_rst_busy",   32'(bus.busy),         32'd0);
      repeat (8) @(posedge clk);
      #2;
      check("mid_rst_idle", 32'(bus.busy), 32'd0);

      // Round-robin from a reset pointer: A0..A7, A0
      m_req = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         m_prio[i] = 3;
         m_data[i] = 8'($urandom);
      end
      run_frames(9, 1'b0, 1'b0);

`ifdef SERIAL_ARB_STARVATION_GUARD_EN
      // Starved ch0 overtakes ch3 once aged to the limit
      do_reset();
      m_req = 8'h09;
      for (int i = 0; i < 8; i++) begin
         m_prio[i] = 0;
         m_data[i] = 8'($urandom);
      end
      m_prio[3] = 7;
      run_frames(6, 1'b0, 1'b0);
`endif

      // Randomized batches with random serializer backpressure
      bp_rand = 1'b1;
      for (int it = 0; it < 40; it++) begin
         m_req = 8'($urandom_range(1, 255));
         for (int i = 0; i < 8; i++) begin
            m_prio[i] = int'($urandom_range(0, 7));
            m_data[i] = 8'($urandom);
         end
         pop = 1'($urandom_range(0, 1));
         n = pop ? $countones(m_req) : int'($urandom_range(1, 3));
         run_frames(n, pop, !pop && n == 1);
      end
      bp_rand = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
